// File: rtl/scomp_conv_pkg.sv
// Shared types and helpers for the serial two's-complement to thermometer receive path.
package scomp_conv_pkg;

  localparam int WIDTH_DEF   = 5;
  localparam int THERM_W_DEF = 2 ** (WIDTH_DEF - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit i is set when i < mag, so mag = 2**(WIDTH-1) lights every bit.
  function automatic logic [THERM_W_DEF-1:0] mag_to_therm(input logic [WIDTH_DEF-1:0] mag);
    logic [THERM_W_DEF-1:0] t;
    t = '0;
    for (int i = 0; i < THERM_W_DEF; i++) begin
      t[i] = (i < int'(mag));
    end
    return t;
  endfunction

endpackage

// File: rtl/scomp_to_therm_decode.sv
// Combinational decode of a two's-complement word into sign, magnitude and thermometer code.
// Zero latency; no flow control.
module scomp_to_therm_decode
  import scomp_conv_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int THERM_W = 2 ** (WIDTH - 1)
) (
  input  logic [WIDTH-1:0]   word_i,
  output logic               sign_o,
  output logic [WIDTH-1:0]   mag_o,
  output logic [THERM_W-1:0] therm_o
);

  // The most negative word negates to itself, which read unsigned is 2**(WIDTH-1).
  assign sign_o  = word_i[WIDTH-1];
  assign mag_o   = sign_o ? ((~word_i) + WIDTH'(1)) : word_i;
  assign therm_o = mag_to_therm(mag_o);

endmodule

// File: rtl/serial_scomp_to_thermometer.sv
// Deserializes LSB-first two's-complement words and registers their sign/magnitude/thermometer decode.
// Outputs load on the edge sampling the MSB; in_valid low stalls the word in place, no backpressure.
module serial_scomp_to_thermometer
  import scomp_conv_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int THERM_W = 2 ** (WIDTH - 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               in_bit,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_word,
  output logic               out_sign,
  output logic [WIDTH-1:0]   out_mag,
  output logic [THERM_W-1:0] out_therm,
  output logic               frame_err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic               done_d, err_d;

  logic               out_valid_q, frame_err_q, out_sign_q;
  logic [WIDTH-1:0]   out_word_q, out_mag_q;
  logic [THERM_W-1:0] out_therm_q;

  logic               dec_sign;
  logic [WIDTH-1:0]   dec_mag;
  logic [THERM_W-1:0] dec_therm;

  // Decode the next-state shift register so the completing MSB is already included.
  scomp_to_therm_decode #(
    .WIDTH   (WIDTH),
    .THERM_W (THERM_W)
  ) u_decode (
    .word_i  (sreg_d),
    .sign_o  (dec_sign),
    .mag_o   (dec_mag),
    .therm_o (dec_therm)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_first) begin
          sreg_d    = '0;
          sreg_d[0] = in_bit;
          cnt_d     = CNT_W'(1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (in_valid) begin
          if (in_first) begin
            err_d     = 1'b1;
            sreg_d    = '0;
            sreg_d[0] = in_bit;
            cnt_d     = CNT_W'(1);
          end else begin
            sreg_d[cnt_q] = in_bit;
            if (cnt_q == LAST) begin
              done_d  = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      out_word_q  <= '0;
      out_sign_q  <= 1'b0;
      out_mag_q   <= '0;
      out_therm_q <= '0;
    end else begin
      out_valid_q <= done_d;
      frame_err_q <= err_d;
      if (done_d) begin
        out_word_q  <= sreg_d;
        out_sign_q  <= dec_sign;
        out_mag_q   <= dec_mag;
        out_therm_q <= dec_therm;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign out_word  = out_word_q;
  assign out_sign  = out_sign_q;
  assign out_mag   = out_mag_q;
  assign out_therm = out_therm_q;

endmodule

// File: tb/tb_serial_scomp_to_thermometer.sv
// Directed bench for serial_scomp_to_thermometer with hand-computed expected decodes.
module tb_serial_scomp_to_thermometer;

  localparam int WIDTH   = 5;
  localparam int THERM_W = 16;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_first;
  logic               in_bit;
  logic               out_valid;
  logic [WIDTH-1:0]   out_word;
  logic               out_sign;
  logic [WIDTH-1:0]   out_mag;
  logic [THERM_W-1:0] out_therm;
  logic               frame_err;

  int n_checks;
  int n_fail;
  int vld_cnt;
  int err_cnt;
  int both_cnt;
  int v0, e0;

  serial_scomp_to_thermometer #(
    .WIDTH   (WIDTH),
    .THERM_W (THERM_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_therm (out_therm),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) vld_cnt++;
    if (frame_err) err_cnt++;
    if (out_valid && frame_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic b);
    @(negedge clk);
    in_valid = v;
    in_first = f;
    in_bit   = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) drive(1'b1, i == 0, w[i]);
  endtask

  task automatic chk_out(input string tag, input logic [WIDTH-1:0] w, input logic s,
                         input logic [WIDTH-1:0] m, input logic [THERM_W-1:0] t);
    chk({tag, ".word"},  32'(out_word),  32'(w));
    chk({tag, ".sign"},  32'(out_sign),  32'(s));
    chk({tag, ".mag"},   32'(out_mag),   32'(m));
    chk({tag, ".therm"}, 32'(out_therm), 32'(t));
  endtask

  initial begin
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
    n_checks = 0; n_fail = 0;
    vld_cnt = 0; err_cnt = 0; both_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_bit = 1'b0;

    idle(3);
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.ferr",  32'(frame_err), 0);
    chk_out("rst", 5'h00, 1'b0, 5'd0, 16'h0000);
    rst = 1'b0;
    idle(2);

    // +5
    v0 = vld_cnt;
    send_word(5'b00101);
    idle(1);
    chk("p5.valid", 32'(out_valid), 1);
    chk_out("p5", 5'h05, 1'b0, 5'd5, 16'h001F);
    idle(2);
    chk("p5.valid_drop", 32'(out_valid), 0);
    chk("p5.pulses", 32'(vld_cnt - v0), 1);

    // -16, most negative
    v0 = vld_cnt;
    send_word(5'b10000);
    idle(1);
    chk("m16.valid", 32'(out_valid), 1);
    chk_out("m16", 5'h10, 1'b1, 5'd16, 16'hFFFF);
    idle(2);
    chk("m16.pulses", 32'(vld_cnt - v0), 1);

    // -1 with a 2-cycle stall between bit 2 and bit 3
    v0 = vld_cnt;
    wa = 5'b11111;
    for (int i = 0; i < 3; i++) drive(1'b1, i == 0, wa[i]);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      chk("stall.valid", 32'(out_valid), 0);
      chk("stall.hold",  32'(out_word), 32'h10);
    end
    drive(1'b1, 1'b0, wa[3]);
    drive(1'b1, 1'b0, wa[4]);
    idle(1);
    chk("m1.valid", 32'(out_valid), 1);
    chk_out("m1", 5'h1F, 1'b1, 5'd1, 16'h0001);
    idle(2);
    chk("m1.pulses", 32'(vld_cnt - v0), 1);

    // 3 bits of an aborted word, then -3
    v0 = vld_cnt; e0 = err_cnt;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    wa = 5'b11101;
    drive(1'b1, 1'b1, wa[0]);
    drive(1'b1, 1'b0, wa[1]);
    chk("abort.ferr", 32'(frame_err), 1);
    chk("abort.novalid", 32'(out_valid), 0);
    for (int i = 2; i < WIDTH; i++) drive(1'b1, 1'b0, wa[i]);
    idle(1);
    chk("m3.valid", 32'(out_valid), 1);
    chk("m3.ferr",  32'(frame_err), 0);
    chk_out("m3", 5'h1D, 1'b1, 5'd3, 16'h0007);
    idle(2);
    chk("abort.pulses", 32'(vld_cnt - v0), 1);
    chk("abort.errs",   32'(err_cnt - e0), 1);

    // 0 then +15 back-to-back, pulses 5 cycles apart
    v0 = vld_cnt;
    send_word(5'b00000);
    wb = 5'b01111;
    for (int i = 0; i < WIDTH; i++) begin
      drive(1'b1, i == 0, wb[i]);
      if (i == 0) begin
        chk("b2b0.valid", 32'(out_valid), 1);
        chk_out("b2b0", 5'h00, 1'b0, 5'd0, 16'h0000);
      end else begin
        chk("b2b.gap", 32'(out_valid), 0);
      end
    end
    idle(1);
    chk("b2b15.valid", 32'(out_valid), 1);
    chk_out("b2b15", 5'h0F, 1'b0, 5'd15, 16'h7FFF);
    idle(2);
    chk("b2b.pulses", 32'(vld_cnt - v0), 2);

    // reset after 2 bits, then unframed bits
    v0 = vld_cnt; e0 = err_cnt;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_first = 1'b0; in_bit = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_out("mrst", 5'h00, 1'b0, 5'd0, 16'h0000);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1);
    idle(2);
    chk("mrst.valid", 32'(out_valid), 0);
    chk_out("unframed", 5'h00, 1'b0, 5'd0, 16'h0000);
    chk("mrst.pulses", 32'(vld_cnt - v0), 0);
    chk("mrst.errs",   32'(err_cnt - e0), 0);

    send_word(5'b00111);
    idle(1);
    chk("p7.valid", 32'(out_valid), 1);
    chk_out("p7", 5'h07, 1'b0, 5'd7, 16'h007F);
    idle(2);
    chk("overlap", 32'(both_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
